// File: rtl/uart_boot_host.sv
// uart_boot_host: boots a CPU over a byte UART link.
// Sends length and program after SYNC_PROG, stdin after SYNC_STDIN, then captures output.
module uart_boot_host #(
  parameter int WORD_W = 32,
  parameter int LEN_BYTES = 4,
  parameter logic [7:0] SYNC_PROG = 8'h99,
  parameter logic [7:0] SYNC_STDIN = 8'hAA,
  parameter int ADDR_W = 16,
  parameter int RES_DEPTH = 4096,
  parameter int IDLE_TIMEOUT = 1000000,
  parameter int SYNC_TIMEOUT = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic [8*LEN_BYTES-1:0] prog_len,
  input  logic [ADDR_W-1:0] stdin_len,
  output logic [ADDR_W-1:0] prog_addr,
  input  logic [WORD_W-1:0] prog_rdata,
  output logic [ADDR_W-1:0] stdin_addr,
  input  logic [7:0] stdin_rdata,
  output logic [7:0] tx_data,
  output logic tx_start,
  input  logic tx_busy,
  input  logic [7:0] rx_data,
  input  logic rx_valid,
  output logic res_we,
  output logic [ADDR_W-1:0] res_addr,
  output logic [7:0] res_data,
  output logic [ADDR_W:0] res_count,
  output logic busy,
  output logic done,
  output logic err_sync_to,
  output logic res_overflow
);
  localparam int LW = 8*LEN_BYTES;
  localparam logic [7:0] LEN_LAST = 8'(LEN_BYTES-1);
  localparam logic [7:0] WB_LAST = 8'(WORD_W/8-1);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(RES_DEPTH);
  localparam logic [31:0] IDLE_LAST = 32'(IDLE_TIMEOUT-1);
  localparam logic [31:0] SYNC_LAST = 32'(SYNC_TIMEOUT-1);
  localparam bit SYNC_EN = SYNC_TIMEOUT > 0;

  typedef enum logic [3:0] {
    IDLE, WAIT_A, SEND_LEN, PROG_FETCH, PROG_SEND,
    WAIT_B, STDIN_SEND, CAPTURE, DONE
  } state_t;

  state_t state, state_nx;
  logic [LW-1:0] plen, pcnt;
  logic [ADDR_W-1:0] slen;
  logic [7:0] cnt;
  logic [1:0] ph;
  logic [WORD_W-1:0] word;
  logic [31:0] timer;
  logic tx_ok, rx_a, rx_b, cap, sync_to, go, snd;
  logic [7:0] snd_byte;

  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
  // one guard cycle after every strobe covers the UART's busy rise latency
  assign tx_ok = !tx_busy && !tx_start;
  assign rx_a = rx_valid && rx_data == SYNC_PROG;
  assign rx_b = rx_valid && rx_data == SYNC_STDIN;
  assign cap = state == STDIN_SEND || state == CAPTURE;
  assign sync_to = SYNC_EN && timer == SYNC_LAST;
  assign go = start && (state == IDLE || state == DONE);

  always_comb begin
    state_nx = state;
    snd = 1'b0;
    snd_byte = 8'h00;
    unique case (state)
      IDLE: if (start) state_nx = WAIT_A;
      WAIT_A: begin
        if (rx_a) state_nx = SEND_LEN;
        else if (sync_to) state_nx = DONE;
      end
      SEND_LEN: if (tx_ok) begin
        snd = 1'b1;
        snd_byte = 8'(plen >> {cnt, 3'b000});
        if (cnt == LEN_LAST) state_nx = PROG_FETCH;
      end
      PROG_FETCH: state_nx = (plen == '0) ? WAIT_B : PROG_SEND;
      PROG_SEND: if (ph != 2'd0 && tx_ok) begin
        snd = 1'b1;
        snd_byte = word[7:0];
        if (pcnt + 1'b1 == plen) state_nx = WAIT_B;
        else if (cnt == WB_LAST) state_nx = PROG_FETCH;
      end
      WAIT_B: begin
        if (rx_b) state_nx = (slen == '0) ? CAPTURE : STDIN_SEND;
        else if (sync_to) state_nx = DONE;
      end
      STDIN_SEND: if (ph == 2'd2 && tx_ok) begin
        snd = 1'b1;
        snd_byte = word[7:0];
        if (stdin_addr + 1'b1 == slen) state_nx = CAPTURE;
      end
      CAPTURE: if (!rx_valid && timer == IDLE_LAST) state_nx = DONE;
      DONE: if (start) state_nx = WAIT_A;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      plen <= '0;
      pcnt <= '0;
      slen <= '0;
      cnt <= '0;
      ph <= '0;
      word <= '0;
      timer <= '0;
      prog_addr <= '0;
      stdin_addr <= '0;
      tx_data <= '0;
      tx_start <= 1'b0;
      res_we <= 1'b0;
      res_addr <= '0;
      res_data <= '0;
      res_count <= '0;
      err_sync_to <= 1'b0;
      res_overflow <= 1'b0;
    end else begin
      state <= state_nx;
      tx_start <= snd;
      res_we <= 1'b0;
      if (snd) tx_data <= snd_byte;
      if (state_nx != state || (cap && rx_valid)) timer <= '0;
      else timer <= timer + 1'b1;
      if (go) begin
        plen <= prog_len;
        slen <= stdin_len;
        pcnt <= '0;
        cnt <= '0;
        ph <= '0;
        prog_addr <= '0;
        stdin_addr <= '0;
        res_count <= '0;
        err_sync_to <= 1'b0;
        res_overflow <= 1'b0;
      end
      if (sync_to && ((state == WAIT_A && !rx_a) ||
                      (state == WAIT_B && !rx_b)))
        err_sync_to <= 1'b1;
      if (state == SEND_LEN && snd)
        cnt <= (cnt == LEN_LAST) ? 8'd0 : cnt + 8'd1;
      if (state == PROG_SEND) begin
        if (ph == 2'd0) begin
          word <= prog_rdata;
          ph <= 2'd1;
        end else if (snd) begin
          word <= word >> 8;
          pcnt <= pcnt + 1'b1;
          cnt <= cnt + 8'd1;
          if (state_nx != PROG_SEND) begin
            cnt <= '0;
            ph <= '0;
            prog_addr <= prog_addr + 1'b1;
          end
        end
      end
      // stdin: ph 0 = address out, 1 = data back, 2 = ready to send
      if (state == STDIN_SEND) begin
        if (ph == 2'd0) ph <= 2'd1;
        else if (ph == 2'd1) begin
          word[7:0] <= stdin_rdata;
          ph <= 2'd2;
        end else if (snd) begin
          stdin_addr <= stdin_addr + 1'b1;
          ph <= 2'd0;
        end
      end
      if (cap && rx_valid) begin
        if (res_count < DEPTH) begin
          res_we <= 1'b1;
          res_addr <= res_count[ADDR_W-1:0];
          res_data <= rx_data;
          res_count <= res_count + 1'b1;
        end else begin
          res_overflow <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_boot_host.sv
// tb_uart_boot_host: plays CPU and UART peer around uart_boot_host.
// Expected tx stream and result buffer come from a byte-level protocol model.
module tb_uart_boot_host;
  localparam int AW = 8;
  localparam int DEPTH = 4;
  localparam int ITO = 40;
  localparam int STO = 100;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [31:0] prog_len = '0;
  logic [AW-1:0] stdin_len = '0;
  logic [AW-1:0] prog_addr, stdin_addr, res_addr;
  logic [31:0] prog_rdata = '0;
  logic [7:0] stdin_rdata = '0;
  logic [7:0] tx_data, res_data;
  logic tx_start, res_we, busy, done, err_sync_to, res_overflow;
  logic tx_busy = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic [AW:0] res_count;

  logic [31:0] prog_mem [256];
  logic [7:0] stdin_mem [256];
  logic [7:0] txq[$];
  logic [7:0] resq[$];
  logic [AW-1:0] addrq[$];
  logic prev_start = 1'b0;
  int bcnt = 0;
  int n_chk = 0;
  int n_pass = 0;

  uart_boot_host #(
    .WORD_W(32), .LEN_BYTES(4), .SYNC_PROG(8'h99), .SYNC_STDIN(8'hAA),
    .ADDR_W(AW), .RES_DEPTH(DEPTH), .IDLE_TIMEOUT(ITO), .SYNC_TIMEOUT(STO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .prog_len(prog_len), .stdin_len(stdin_len),
    .prog_addr(prog_addr), .prog_rdata(prog_rdata),
    .stdin_addr(stdin_addr), .stdin_rdata(stdin_rdata),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
    .res_count(res_count), .busy(busy), .done(done),
    .err_sync_to(err_sync_to), .res_overflow(res_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(posedge clk) begin
    prog_rdata <= prog_mem[prog_addr];
    stdin_rdata <= stdin_mem[stdin_addr];
    if (tx_start) begin
      bcnt <= int'($urandom_range(1, 4));
      tx_busy <= 1'b1;
    end else if (bcnt > 1) begin
      bcnt <= bcnt - 1;
    end else begin
      bcnt <= 0;
      tx_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    prev_start <= tx_start;
    if (tx_start) begin
      chk("tx_guard", {62'd0, tx_busy, prev_start}, 64'd0);
      txq.push_back(tx_data);
    end
    if (res_we) begin
      resq.push_back(res_data);
      addrq.push_back(res_addr);
    end
  end

  function automatic logic [7:0] garbage();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == 8'h99 || b == 8'hAA) b = 8'h55;
    return b;
  endfunction

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start(input int pl, input int sl);
    @(negedge clk);
    txq.delete();
    resq.delete();
    addrq.delete();
    start = 1'b1;
    prog_len = 32'(pl);
    stdin_len = AW'(sl);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input int pl, input int sl, input bq_t eb);
    logic [7:0] exp[$];
    int i;
    int nst;
    for (int k = 0; k < 4; k++) exp.push_back(8'(pl >> (8*k)));
    for (int k = 0; k < pl; k++)
      exp.push_back(8'(prog_mem[k/4] >> (8*(k%4))));
    for (int k = 0; k < sl; k++) exp.push_back(stdin_mem[k]);
    nst = (eb.size() < DEPTH) ? eb.size() : DEPTH;

    pulse_start(pl, sl);
    chk("busy_run", {63'd0, busy}, 64'd1);
    repeat ($urandom_range(0, 20)) @(negedge clk);
    send_rx(garbage());
    chk("no_tx_pre_sync", txq.size(), 0);
    send_rx(8'h99);
    for (i = 0; i < 4000 && txq.size() < 4 + pl; i++) @(negedge clk);
    chk("prog_wait", {63'd0, txq.size() >= 4 + pl}, 64'd1);
    for (i = 0; i < 20 && tx_busy; i++) @(negedge clk);
    send_rx(garbage());
    send_rx(8'hAA);
    foreach (eb[k]) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_rx(eb[k]);
    end
    for (i = 0; i < 4000 && !done; i++) @(negedge clk);
    chk("done", {63'd0, done}, 64'd1);
    chk("busy_done", {63'd0, busy}, 64'd0);
    chk("tx_len", txq.size(), exp.size());
    foreach (exp[k])
      if (k < txq.size()) chk($sformatf("tx_byte%0d", k), txq[k], exp[k]);
    chk("res_count", res_count, nst);
    chk("res_writes", resq.size(), nst);
    for (int k = 0; k < nst && k < resq.size(); k++) begin
      chk("res_data", resq[k], eb[k]);
      chk("res_addr", addrq[k], k);
    end
    chk("overflow", {63'd0, res_overflow}, {63'd0, eb.size() > DEPTH});
    chk("err_sync", {63'd0, err_sync_to}, 64'd0);
  endtask

  task automatic rand_mem();
    for (int k = 0; k < 256; k++) begin
      prog_mem[k] = $urandom;
      stdin_mem[k] = 8'($urandom);
    end
  endtask

  initial begin
    bq_t eb;
    int n;
    rand_mem();
    repeat (3) @(negedge clk);
    chk("reset_outs", {tx_start, tx_data, res_we, res_addr, res_data,
      res_count, busy, done, err_sync_to, res_overflow,
      prog_addr, stdin_addr}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    prog_mem[0] = 32'h04030201;
    prog_mem[1] = 32'h08070605;
    stdin_mem[0] = 8'h41;
    stdin_mem[1] = 8'h42;
    eb = '{8'h61, 8'h62, 8'h63};
    run(8, 2, eb);
    eb = '{8'h11, 8'h22};
    run(6, 1, eb);
    run(0, 0, eb);
    eb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run(3, 2, eb);

    pulse_start(4, 1);
    repeat (99) @(negedge clk);
    chk("sync_to_early", {62'd0, done, err_sync_to}, 64'd0);
    @(negedge clk);
    chk("sync_to_done", {63'd0, done}, 64'd1);
    chk("sync_to_err", {63'd0, err_sync_to}, 64'd1);
    chk("sync_to_tx", txq.size(), 0);

    pulse_start(12, 2);
    send_rx(8'h99);
    for (int i = 0; i < 4000 && txq.size() < 6; i++) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_outs", {tx_start, tx_data, res_we, res_addr, res_data,
      res_count, busy, done, err_sync_to, res_overflow,
      prog_addr, stdin_addr}, 64'd0);
    n = txq.size();
    repeat (10) @(negedge clk);
    chk("abort_no_tx", txq.size(), n);
    reset_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 8; r++) begin
      rand_mem();
      eb.delete();
      repeat ($urandom_range(0, 6)) eb.push_back(8'($urandom));
      run(int'($urandom_range(0, 20)), int'($urandom_range(0, 6)), eb);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
